// File: rtl/ei_axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory: burst kinds, response codes, FSM states and burst context.
package ei_axi4_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_e      burst;
  } burst_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address and burst legality check; no state, no latency.
// err_o covers the whole burst: reserved type, oversize beat, illegal wrap length, or any beat past the memory end.
module ei_axi4_burst_addr_gen
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  burst_e      burst_i,
  output logic [31:0] next_addr_o,
  output logic        err_o
);

  localparam int          STRB_W    = DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_SIZE  = 3'($clog2(STRB_W));
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * STRB_W);

  logic [31:0] bytes;
  logic [31:0] aligned;
  logic [31:0] wrap_bytes;
  logic [31:0] wrap_base;
  logic [31:0] incr_next;
  logic [32:0] last_addr;

  assign bytes      = 32'd1 << size_i;
  assign aligned    = addr_i & ~(bytes - 32'd1);
  assign wrap_bytes = (32'(len_i) + 32'd1) << size_i;
  assign wrap_base  = aligned & ~(wrap_bytes - 32'd1);
  assign incr_next  = aligned + bytes;

  // last_addr is the highest byte-beat address the burst will touch, so a
  // range error is known before the first beat is written.
  always_comb begin
    next_addr_o = addr_i;
    last_addr   = {1'b0, addr_i};
    case (burst_i)
      INCR: begin
        next_addr_o = incr_next;
        last_addr   = {1'b0, aligned} + (33'(len_i) << size_i);
      end
      WRAP: begin
        next_addr_o = wrap_base | (incr_next & (wrap_bytes - 32'd1));
        last_addr   = {1'b0, wrap_base} + {1'b0, wrap_bytes} - {1'b0, bytes};
      end
      default: ;
    endcase
  end

  assign err_o = (burst_i == RSVD)
              || (size_i > MAX_SIZE)
              || ((burst_i == WRAP) && !wrap_len_ok(len_i))
              || (last_addr >= MEM_BYTES);

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave over on-chip memory: wready 1 cycle after AW, first R beat 1 cycle after AR, R beats back-to-back.
// One burst per direction; R and B hold while rready/bready low. EI_AXI4_SLV_WLAST_CHECK_EN flags wlast misuse as SLVERR.
module ei_axi4_slave_mem
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [31:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wr_state_e   w_state_q, w_state_d;
  burst_t      wr_q, wr_d, aw_req, wgen_in;
  logic [7:0]  wbeat_q, wbeat_d;
  logic        werr_q, werr_d, wlerr_q, wlerr_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        awready_q, wready_q, bvalid_q;
  logic        wgen_err, mem_we, w_last_beat;
  logic [31:0] wgen_next;
  logic [IDX_W-1:0] widx;

  assign aw_req      = '{addr: awaddr, len: awlen, size: awsize, burst: burst_e'(awburst)};
  assign wgen_in     = (w_state_q == W_IDLE) ? aw_req : wr_q;
  assign w_last_beat = (wbeat_q == wr_q.len);
  assign widx        = wr_q.addr[IDX_W+OFF_W-1:OFF_W];

  ei_axi4_burst_addr_gen #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wr_addr_gen (
    .addr_i(wgen_in.addr), .len_i(wgen_in.len), .size_i(wgen_in.size), .burst_i(wgen_in.burst),
    .next_addr_o(wgen_next), .err_o(wgen_err)
  );

  always_comb begin
    w_state_d = w_state_q;
    wr_d      = wr_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    wlerr_d   = wlerr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wr_d      = aw_req;
        wbeat_d   = 8'd0;
        werr_d    = wgen_err;
        wlerr_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        mem_we    = !werr_q;
        wr_d.addr = wgen_next;
        wbeat_d   = wbeat_q + 8'd1;
`ifdef EI_AXI4_SLV_WLAST_CHECK_EN
        wlerr_d   = wlerr_q | (wlast != w_last_beat);
`endif
        if (w_last_beat) begin
          w_state_d = W_RESP;
          bresp_d   = (werr_q || wlerr_d) ? SLVERR : OKAY;
        end
      end
      W_RESP: if (bready && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

`ifndef EI_AXI4_SLV_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif

  // Handshake outputs are registered decodes of the next state so that they
  // read 0 during reset and rise on the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      wr_q      <= '0;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      bresp_q   <= OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wr_q      <= wr_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      wlerr_q   <= wlerr_d;
      bresp_q   <= bresp_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  rd_state_e             r_state_q, r_state_d;
  burst_t                rd_q, rd_d, ar_req, rgen_in;
  logic [7:0]            rbeat_q, rbeat_d;
  logic                  rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  arready_q, rvalid_q, rlast_q;
  logic                  rgen_err;
  logic [31:0]           rgen_next;

  assign ar_req  = '{addr: araddr, len: arlen, size: arsize, burst: burst_e'(arburst)};
  assign rgen_in = (r_state_q == R_IDLE) ? ar_req : rd_q;

  ei_axi4_burst_addr_gen #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rd_addr_gen (
    .addr_i(rgen_in.addr), .len_i(rgen_in.len), .size_i(rgen_in.size), .burst_i(rgen_in.burst),
    .next_addr_o(rgen_next), .err_o(rgen_err)
  );

  // rdata is fetched one edge ahead of each beat; a same-edge write is not
  // yet visible, so a colliding read returns the old word.
  always_comb begin
    r_state_d = r_state_q;
    rd_d      = rd_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        r_state_d = R_DATA;
        rd_d      = ar_req;
        rbeat_d   = 8'd0;
        rerr_d    = rgen_err;
        rresp_d   = rgen_err ? SLVERR : OKAY;
        rdata_d   = rgen_err ? '0 : mem_q[araddr[IDX_W+OFF_W-1:OFF_W]];
      end
      R_DATA: if (rready && rvalid_q) begin
        if (rbeat_q == rd_q.len) begin
          r_state_d = R_IDLE;
        end else begin
          rd_d.addr = rgen_next;
          rbeat_d   = rbeat_q + 8'd1;
          rdata_d   = rerr_q ? '0 : mem_q[rgen_next[IDX_W+OFF_W-1:OFF_W]];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rd_q      <= '0;
      rbeat_q   <= 8'd0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rd_q      <= rd_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
      rlast_q   <= (r_state_d == R_DATA) && (rbeat_d == rd_d.len);
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem (DATA_WIDTH=32, MEM_DEPTH=1024): bursts, strobes, errors, stalls, reset.
module tb_ei_axi4_slave_mem;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rs [16];
  logic        rl [16];

  ei_axi4_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 aclk = ~aclk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] strb, input int bdelay,
                           output logic [1:0] resp);
    int n;
    awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL wready_latency got %b want 1", wready); end
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 20) begin tick(); n++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency got %b want 1", bvalid); end
    resp = bresp;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b1 || bresp !== resp) begin
        errors++; $display("FAIL b_stall cycle %0d got bvalid=%b bresp=%b want 1/%b", i, bvalid, bresp, resp);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_done got bvalid=%b want 0", bvalid); end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [15:0] pat, output int nb);
    logic [31:0] sd;
    logic [1:0]  ss;
    logic        sl;
    logic        stalled;
    int          n;
    araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency got %b want 1", rvalid); end
    nb = 0; stalled = 1'b0; n = 0;
    sd = '0; ss = '0; sl = 1'b0;
    while (nb <= int'(len) && n < 64) begin
      rready = (n < 16) ? pat[n] : 1'b1;
      if (stalled) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== sd || rresp !== ss || rlast !== sl) begin
          errors++;
          $display("FAIL r_stall_stable got %b/%h/%b/%b want 1/%h/%b/%b", rvalid, rdata, rresp, rlast, sd, ss, sl);
        end
      end
      stalled = 1'b0;
      if (rvalid === 1'b1) begin
        if (rready) begin
          rd[nb] = rdata; rs[nb] = rresp; rl[nb] = rlast; nb++;
        end else begin
          stalled = 1'b1; sd = rdata; ss = rresp; sl = rlast;
        end
      end else begin
        checks++; errors++;
        $display("FAIL r_bubble beat %0d got rvalid=%b want 1", nb, rvalid);
      end
      tick();
      n++;
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_done got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b%b%b%b%b%b %b %b %h want all 0",
                         awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata);
    end
    aresetn = 1'b1;
    checks++;
    if (awready !== 1'b0) begin errors++; $display("FAIL awready_before_edge got %b want 0", awready); end
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge got aw=%b ar=%b want 1/1", awready, arready);
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    int nb;
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    axi_write(32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 0, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", resp); end
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (nb != 4) begin errors++; $display("FAIL incr_beats got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== 32'hA0 + 32'(i) || rs[i] !== 2'b00 || rl[i] !== (i == 3)) begin
        errors++; $display("FAIL incr_beat%0d got %h/%b/%b want %h/00/%b", i, rd[i], rs[i], rl[i], 32'hA0 + 32'(i), i == 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0]  resp;
    logic [31:0] exp [4];
    int nb;
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
    axi_write(32'h30, 8'd3, 3'd2, 2'b01, 4'hF, 0, resp);
    exp = '{32'hC2, 32'hC3, 32'hC0, 32'hC1};
    axi_read(32'h38, 8'd3, 3'd2, 2'b10, 16'hFFFF, nb);
    checks++;
    if (nb != 4) begin errors++; $display("FAIL wrap_beats got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== exp[i] || rs[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_beat%0d got %h/%b want %h/00", i, rd[i], rs[i], exp[i]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    int nb;
    wd[0] = 32'h12345678;
    axi_write(32'h80, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
    wd[0] = 32'hFFFFFFFF;
    axi_write(32'h80, 8'd0, 3'd2, 2'b01, 4'b0010, 0, resp);
    axi_read(32'h80, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'h1234FF78 || rl[0] !== 1'b1) begin
      errors++; $display("FAIL strobe_merge got %h rlast=%b want 1234ff78 rlast=1", rd[0], rl[0]);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp;
    int nb;
    wd[0] = 32'h55550000;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
    wd[0] = 32'h0FC0FFEE;
    axi_write(32'hFFC, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
    wd[0] = 32'hDEADBEEF; wd[1] = 32'hDEADBEEF;
    axi_write(32'h10, 8'd0, 3'd2, 2'b11, 4'hF, 0, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL rsvd_bresp got %b want 10", resp); end
    axi_write(32'h1000, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b want 10", resp); end
    axi_write(32'hFFC, 8'd1, 3'd2, 2'b01, 4'hF, 0, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL cross_end_bresp got %b want 10", resp); end
    axi_read(32'h10, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'hA0) begin errors++; $display("FAIL rsvd_mem got %h want a0", rd[0]); end
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'h55550000) begin errors++; $display("FAIL oor_mem got %h want 55550000", rd[0]); end
    axi_read(32'hFFC, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'h0FC0FFEE || rs[0] !== 2'b00) begin
      errors++; $display("FAIL cross_end_mem got %h/%b want 0fc0ffee/00", rd[0], rs[0]);
    end
    axi_read(32'h1000, 8'd1, 3'd2, 2'b01, 16'hFFFF, nb);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd[i] !== 32'h0 || rs[i] !== 2'b10 || rl[i] !== (i == 1)) begin
        errors++; $display("FAIL oor_read%0d got %h/%b/%b want 0/10/%b", i, rd[i], rs[i], rl[i], i == 1);
      end
    end
    axi_read(32'h10, 8'd2, 3'd2, 2'b10, 16'hFFFF, nb);
    checks++;
    if (nb != 3 || rd[0] !== 32'h0 || rs[0] !== 2'b10 || rs[2] !== 2'b10) begin
      errors++; $display("FAIL wrap_len_err got n=%0d %h/%b want 3 0/10", nb, rd[0], rs[0]);
    end
    axi_read(32'h10, 8'd0, 3'd3, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'h0 || rs[0] !== 2'b10) begin
      errors++; $display("FAIL size_err got %h/%b want 0/10", rd[0], rs[0]);
    end
  endtask

  task automatic test_stall();
    logic [1:0] resp;
    int nb;
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, 16'hFFF9, nb);
    checks++;
    if (nb != 4) begin errors++; $display("FAIL stall_beats got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== 32'hA0 + 32'(i) || rl[i] !== (i == 3)) begin
        errors++; $display("FAIL stall_beat%0d got %h/%b want %h/%b", i, rd[i], rl[i], 32'hA0 + 32'(i), i == 3);
      end
    end
    wd[0] = 32'h00000077;
    axi_write(32'h40, 8'd0, 3'd2, 2'b01, 4'hF, 5, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL bstall_bresp got %b want 00", resp); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    int nb;
    int n;
    awaddr = 32'h100; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hB0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      tick();
    end
    wdata = 32'hB2;
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs got %b%b%b%b%b%b %b %b %h want all 0",
                         awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata);
    end
    wvalid = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    checks++;
    if (awready !== 1'b0) begin errors++; $display("FAIL midreset_aw_before got %b want 0", awready); end
    tick();
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL midreset_aw_after got %b want 1", awready); end
    axi_read(32'h100, 8'd1, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'hB0 || rd[1] !== 32'hB1) begin
      errors++; $display("FAIL partial_kept got %h %h want b0 b1", rd[0], rd[1]);
    end
    wd[0] = 32'hE0; wd[1] = 32'hE1;
    axi_write(32'h100, 8'd1, 3'd2, 2'b01, 4'hF, 0, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL post_reset_bresp got %b want 00", resp); end
    axi_read(32'h100, 8'd1, 3'd2, 2'b01, 16'hFFFF, nb);
    checks++;
    if (rd[0] !== 32'hE0 || rd[1] !== 32'hE1) begin
      errors++; $display("FAIL post_reset_data got %h %h want e0 e1", rd[0], rd[1]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_slverr();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

Synthesizable AXI4 slave responder backed by a word-addressed on-chip memory. It sits at the slave end of the VIP's AXI4 bus and answers the master driver on all five channels: AW/W/B for writes, AR/R for reads. It gives the bench a real RTL DUT with FIXED/INCR/WRAP burst handling and OKAY/SLVERR responses.

## Interface
- DATA_WIDTH, 32: data bus width in bits; legal values 32, 64, 128.
- MEM_DEPTH, 1024: memory size in DATA_WIDTH words; power of two.
- aclk  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- awaddr/awlen/awsize/awburst  in  32/8/3/2  write address channel payload.
- awvalid in 1, awready out 1  write address handshake.
- wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8, wlast in 1  write data payload.
- wvalid in 1, wready out 1  write data handshake.
- bresp out 2, bvalid out 1, bready in 1  write response channel.
- araddr/arlen/arsize/arburst  in  32/8/3/2  read address channel payload.
- arvalid in 1, arready out 1  read address handshake.
- rdata out DATA_WIDTH, rresp out 2, rlast out 1, rvalid out 1, rready in 1  read data channel.

## Operation
- Write FSM: W_IDLE (awready=1) -> AW handshake latches addr/len/size/burst and resets the beat counter -> W_DATA (wready=1). Each W handshake writes the bytes enabled by wstrb, then advances the address. After beat awlen+1 the FSM moves to W_RESP (bvalid=1, bresp held). On bready it returns to W_IDLE.
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA. In R_DATA the block drives rvalid=1 with rdata/rresp/rlast for the current beat. Each R handshake advances the beat. rlast is 1 only on beat arlen+1. The handshake on the last beat returns the FSM to R_IDLE.
- The read and write FSMs run independently and concurrently.
- Address sequence, computed per beat; the transfer size is 2^size bytes:
  - FIXED (00): the address is constant.
  - INCR (01): next address = aligned(addr) + 2^size.
  - WRAP (10): the wrap boundary is (len+1)<<size bytes. The address wraps to the boundary-aligned base.
- Memory index = addr[log2(MEM_DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Narrow writes use wstrb as given. Reads return the full word.
- SLVERR (2'b10) is returned in any of these cases:
  - reserved burst 11;
  - 2^size > DATA_WIDTH/8;
  - WRAP with len not in {1,3,7,15};
  - any beat address >= MEM_DEPTH*DATA_WIDTH/8.
- Effect of a SLVERR burst:
  - Writes: all its writes are suppressed; bresp=SLVERR; all W beats are still accepted.
  - Reads: every beat has rresp=SLVERR and rdata=0.
- Otherwise the response is OKAY (2'b00).
- Read and write to the same word in the same cycle: the read returns the old data.

## Timing
- Reset values:
  - awready, wready, bvalid, arready, rvalid, rlast = 0.
  - bresp, rresp = 00.
  - rdata = 0.
  - Memory contents are not reset.
- awready and arready rise on the first aclk edge after aresetn deasserts.
- AW handshake at edge N -> wready=1 from N+1. The last W handshake at edge M -> bvalid=1 from M+1.
- AR handshake at edge N -> rvalid=1 with beat 0 from N+1. With rready held high there is one beat per cycle, with no bubbles.
- Master stalls:
  - rvalid, rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - bvalid and bresp stay stable until bready.
- awready=0 outside W_IDLE and arready=0 outside R_IDLE, so only one outstanding burst per direction.
- An aresetn assertion mid-burst aborts both FSMs to IDLE immediately. The partial write beats already written remain in memory.

## Configuration
- EI_AXI4_SLV_WLAST_CHECK_EN defined:
  - wlast=1 on a non-final beat, or wlast=0 on the final beat, flags the burst; the flagged burst's bresp is SLVERR.
  - Data already written is kept.
  - The beat count still ends the burst.
- Not defined: wlast is ignored and the beat counter alone ends the burst.

## Structure
- Package ei_axi4_slave_pkg holds:
  - burst enum (FIXED/INCR/WRAP/RSVD);
  - response constants OKAY=2'b00, SLVERR=2'b10;
  - write and read state enums.
- Sub-module ei_axi4_burst_addr_gen: a combinational next-address and error-check function of (addr, len, size, burst). It is instantiated once for the write path and once for the read path.

## Test plan
- INCR write awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, then a matching read -> bresp=OKAY; reads return 0xA0..0xA3 on consecutive cycles; rlast on beat 3 only.
- WRAP read araddr=0x38, arlen=3, arsize=2 -> beat address sequence 0x38, 0x3C, 0x30, 0x34.
- Write with wstrb=4'b0010, wdata=0xFFFFFFFF to a word holding 0x12345678 -> a read returns 0x1234FF78.
- awburst=11, or awaddr=MEM_DEPTH*4 -> bresp=SLVERR and memory unchanged; read of an out-of-range address -> rresp=SLVERR, rdata=0.
- rready toggled 1,0,0,1 during a 4-beat read; bready held low 5 cycles -> outputs stable while stalled; no beat lost or duplicated.
- aresetn pulsed low during beat 2 of an 8-beat write -> all outputs go to their reset values asynchronously; awready=1 one edge after release; a new burst completes with OKAY.
